// File: rtl/hex_word_loader_if.sv
// Byte-stream side of the hex loader: UART receive, echo
// transmit and instruction-memory write port.
interface hex_word_loader_if #(
    parameter int AW = 4
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    echo_data;
    logic          echo_valid;
    logic          echo_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output echo_data,
        output echo_valid,
        input  echo_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  echo_data,
        input  echo_valid,
        output echo_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/hex_word_loader.sv
// Assembles ASCII hex digits from a UART into 32-bit words and
// writes them to instruction memory, echoing every byte taken.
module hex_word_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    hex_word_loader_if.slave bus,
    output logic [AW:0]     word_count,
    output logic            load_done,
    output logic            load_err
);

    typedef enum logic [1:0] {
        COLLECT,
        COMMIT,
        DONE,
        ERROR
    } state_t;

    localparam logic [AW:0]   LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    state_t        state;
    logic [31:0]   shift;
    logic [2:0]    nib_cnt;
    logic [AW-1:0] widx;
    logic [7:0]    echo_data;
    logic          echo_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    logic          accept;
    logic          is_hex;
    logic          is_sep;
    logic          is_go;
    logic [3:0]    nib_val;
    logic [31:0]   shift_nxt;

    // rx_ready is held low under reset, otherwise a pure function
    // of state and the pending echo.
    assign bus.rx_ready = rst_n & (
        ((state == COLLECT) & ~echo_valid) |
        (state == DONE) |
        (state == ERROR));

    assign accept    = bus.rx_valid & bus.rx_ready;
    assign shift_nxt = {shift[27:0], nib_val};

    assign bus.echo_data  = echo_data;
    assign bus.echo_valid = echo_valid;
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;

    always_comb begin
        is_hex  = 1'b0;
        is_sep  = 1'b0;
        is_go   = 1'b0;
        nib_val = 4'h0;
        unique case (1'b1)
            (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39): begin
                is_hex  = 1'b1;
                nib_val = bus.rx_data[3:0];
            end
            (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46),
            (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66): begin
                is_hex  = 1'b1;
                nib_val = bus.rx_data[3:0] + 4'd9;
            end
            (bus.rx_data == 8'h20), (bus.rx_data == 8'h0D),
            (bus.rx_data == 8'h0A), (bus.rx_data == 8'h5F): begin
                is_sep = 1'b1;
            end
            (bus.rx_data == 8'h47), (bus.rx_data == 8'h67): begin
                is_go = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            shift      <= '0;
            nib_cnt    <= '0;
            widx       <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            echo_data  <= 8'h00;
            echo_valid <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (clear) begin
            state      <= COLLECT;
            shift      <= '0;
            nib_cnt    <= '0;
            widx       <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            echo_valid <= 1'b0;
            imem_we    <= 1'b0;
        end else begin
            if (echo_valid && bus.echo_ready) begin
                echo_valid <= 1'b0;
            end
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        echo_data  <= bus.rx_data;
                        echo_valid <= 1'b1;
                        unique case (1'b1)
                            is_hex: begin
                                shift <= shift_nxt;
                                if (nib_cnt == 3'd7) begin
                                    nib_cnt    <= '0;
                                    state      <= COMMIT;
                                    imem_we    <= 1'b1;
                                    imem_addr  <= widx;
                                    imem_wdata <= shift_nxt;
                                end else begin
                                    nib_cnt <= nib_cnt + 3'd1;
                                end
                            end
                            is_sep: ;
                            is_go: begin
                                if (nib_cnt == 3'd0) begin
                                    state     <= DONE;
                                    load_done <= 1'b1;
                                end else begin
                                    state    <= ERROR;
                                    load_err <= 1'b1;
                                end
                            end
                            default: begin
                                state    <= ERROR;
                                load_err <= 1'b1;
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + ONE_C;
                    // Index saturates on the last word so it never wraps.
                    if (word_count == LAST) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        state <= COLLECT;
                        widx  <= widx + ONE_A;
                    end
                end
                DONE: ;
                ERROR: ;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_loader.sv
// Scoreboard bench for hex_word_loader: expected echoes and
// memory writes are queued by stimulus and checked by a monitor.
module tb_hex_word_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [AW:0]   word_count;
    logic          load_done;
    logic          load_err;

    hex_word_loader_if #(.AW(AW)) bus ();

    hex_word_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus.slave),
        .word_count (word_count),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic [7:0] exp_echo[$];
    wr_t        exp_wr[$];
    int         tests;
    int         fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: one pop per echo handshake and per write strobe.
    always @(negedge clk) begin
        if (rst_n && bus.echo_valid && bus.echo_ready) begin
            if (exp_echo.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL echo_unexpected: got %0h expected none",
                         bus.echo_data);
            end else begin
                chk("echo_data", 32'(bus.echo_data),
                    32'(exp_echo.pop_front()));
            end
        end
        if (rst_n && bus.imem_we) begin
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL write_unexpected: got addr %0h data %0h expected none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("imem_addr", 32'(bus.imem_addr), 32'(w.addr));
                chk("imem_wdata", bus.imem_wdata, w.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit echo);
        int t;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.rx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rx_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got rx_ready 0 expected 1");
            bus.rx_valid = 1'b0;
            return;
        end
        if (echo) exp_echo.push_back(b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        cycles(6);
        chk({name, "_echo_left"}, 32'(exp_echo.size()), 0);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 0);
    endtask

    initial begin
        logic [31:0] w;
        bit held;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.echo_ready = 1'b1;
        cycles(3);
        chk("rst_rx_ready", 32'(bus.rx_ready), 0);
        chk("rst_imem_we", 32'(bus.imem_we), 0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 0);
        chk("rst_imem_wdata", bus.imem_wdata, 0);
        chk("rst_echo_valid", 32'(bus.echo_valid), 0);
        chk("rst_echo_data", 32'(bus.echo_data), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_flags", {30'd0, load_done, load_err}, 0);
        rst_n = 1'b1;
        cycles(1);
        chk("idle_rx_ready", 32'(bus.rx_ready), 1);

        // Single word; strobe must be up right after the 8th digit.
        push_wr(0, 32'h00300193);
        send_str("00300193");
        chk("we_timing", 32'(bus.imem_we), 1);
        drain("single");
        chk("single_count", 32'(word_count), 1);
        chk("single_done", 32'(load_done), 0);

        do_clear();
        push_wr(0, 32'hDEADBEEF);
        send_str("dead_beef\n");
        drain("sep");
        chk("sep_err", 32'(load_err), 0);
        chk("sep_count", 32'(word_count), 1);

        // Fill all words then try one more byte.
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            w = {8{4'(i)}} ^ 32'h0F1E2D3C;
            push_wr(i, w);
            for (int k = 7; k >= 0; k--) send(hexc(w[k*4 +: 4]), 1'b1);
        end
        drain("fill");
        chk("fill_done", 32'(load_done), 1);
        chk("fill_count", 32'(word_count), DEPTH);
        send(8'h35, 1'b0);
        drain("fill_extra");
        chk("fill_extra_done", 32'(load_done), 1);
        chk("fill_extra_count", 32'(word_count), DEPTH);

        do_clear();
        chk("clear_done", 32'(load_done), 0);
        push_wr(0, 32'h00000013);
        send_str("00000013G");
        drain("go");
        chk("go_flags", {30'd0, load_done, load_err}, 2);
        chk("go_count", 32'(word_count), 1);

        do_clear();
        send_str("0013G");
        drain("badgo");
        chk("badgo_flags", {30'd0, load_done, load_err}, 1);
        chk("badgo_count", 32'(word_count), 0);

        do_clear();
        send_str("z");
        drain("badchar");
        chk("badchar_err", 32'(load_err), 1);

        // Echo backpressure stalls the next byte.
        do_clear();
        bus.echo_ready = 1'b0;
        send(8'h31, 1'b1);
        bus.rx_data  = 8'h32;
        bus.rx_valid = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_ready || !bus.echo_valid ||
                bus.echo_data != 8'h31) held = 1'b0;
        end
        chk("bp_held", 32'(held), 1);
        bus.echo_ready = 1'b1;
        push_wr(0, 32'h12345678);
        send_str("2345678");
        drain("bp");
        chk("bp_count", 32'(word_count), 1);

        // Reset mid-word discards the partial word.
        do_clear();
        send_str("12345");
        cycles(1);
        rst_n = 1'b0;
        cycles(2);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
        rst_n = 1'b1;
        cycles(1);
        push_wr(0, 32'hFFFFFFFF);
        send_str("FFFFFFFF");
        drain("midrst");
        chk("midrst_count", 32'(word_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_word_loader.md
HEX_WORD_LOADER -- requirements
Module: hex_word_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit instruction-memory words; power of two, 2..256.
REQ-002 Parameter AW, default 4, word-address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 clear  input  1  synchronous restart of the load session.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  rx_data holds a byte.
REQ-008 rx_ready  output  1  loader accepts rx_data this cycle.
REQ-009 echo_data  output  8  byte to retransmit.
REQ-010 echo_valid  output  1  echo_data pending.
REQ-011 echo_ready  input  1  transmitter takes echo_data.
REQ-012 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-013 imem_addr  output  AW  word address of the write.
REQ-014 imem_wdata  output  32  word to write.
REQ-015 word_count  output  AW+1  words committed this session.
REQ-016 load_done  output  1  session ended cleanly; sticky.
REQ-017 load_err  output  1  session aborted by a bad character; sticky.

Function
REQ-018 States: COLLECT, COMMIT, DONE, ERROR.
REQ-019 Byte accepted when rx_valid and rx_ready are both 1 on a rising edge.
REQ-020 rx_ready = 1 in COLLECT with echo_valid = 0; 1 in DONE and ERROR; 0 in COMMIT.
REQ-021 Hex digits: 0x30-0x39 -> 0-9; 0x41-0x46 and 0x61-0x66 -> A-F.
REQ-022 Accepted digit: 32-bit shift register <= {shift[27:0], nibble}; nibble counter += 1. First digit of a word is therefore the MSB.
REQ-023 Acceptance of the 8th digit moves COLLECT -> COMMIT; nibble counter returns to 0.
REQ-024 COMMIT lasts exactly one cycle: imem_we = 1, imem_addr = word index, imem_wdata = assembled word. The strobe is asserted in the cycle after the 8th digit is accepted.
REQ-025 On leaving COMMIT: word index += 1 and word_count += 1. Next state is DONE if word_count reaches DEPTH, else COLLECT.
REQ-026 Separators 0x20, 0x0D, 0x0A, 0x5F are accepted and ignored in any nibble position; shift register and nibble counter are unchanged.
REQ-027 'G'/'g' (0x47/0x67) with nibble counter = 0 -> DONE.
REQ-028 'G'/'g' with nibble counter != 0 -> ERROR; the partial word is not written.
REQ-029 Any other byte accepted in COLLECT -> ERROR.
REQ-030 Echo: every byte accepted in COLLECT, including the one causing DONE or ERROR, is copied to echo_data with echo_valid = 1 on the next edge.
REQ-031 echo_valid holds until echo_ready = 1, then clears on that edge; echo_data is stable while echo_valid = 1.
REQ-032 DONE and ERROR: accepted bytes are discarded, produce no echo and no memory write. State is held until clear.
REQ-033 load_done = 1 only in DONE; load_err = 1 only in ERROR.
REQ-034 clear = 1 returns to COLLECT next edge and zeroes shift register, nibble counter, word index, word_count, load_done, load_err and echo_valid.
REQ-035 clear has priority over a simultaneous byte acceptance; that byte is dropped.
REQ-036 Memory writes never exceed address DEPTH-1; the word index does not wrap within a session.
REQ-037 Outputs are registered; no combinational path from rx_data to imem_* or echo_*. rx_ready may depend combinationally on state and echo_valid only.

Reset
REQ-038 rst_n = 0 asynchronously forces COLLECT, shift register = 0, nibble counter = 0, word index = 0.
REQ-039 Output values under reset: rx_ready 0 while rst_n = 0; imem_we 0; imem_addr 0; imem_wdata 0; echo_valid 0; echo_data 0x00; word_count 0; load_done 0; load_err 0.
REQ-040 Reset asserted mid-word or during COMMIT aborts that word with no write; after deassertion, loading restarts at address 0.

Verification
REQ-041 Single word: send "00300193" -> exactly one imem_we pulse, addr 0, wdata 0x00300193, one cycle after the 8th digit; 8 echoes in order; word_count 1.
REQ-042 Separators and lowercase: send "dead_beef\n" -> addr 0, wdata 0xDEADBEEF; 10 echoes; no ERROR.
REQ-043 Fill: DEPTH=16, send 128 valid digits -> 16 writes at addr 0..15; load_done 1; a 129th byte gets no echo and no write.
REQ-044 Early go and bad go: "00000013G" -> 1 write, then load_done 1. "0013G" after clear -> no write, load_err 1.
REQ-045 Backpressure: hold echo_ready 0 for 20 cycles after the first byte -> rx_ready stays 0 and the next byte waits; releasing echo_ready resumes with no byte lost.
REQ-046 Reset mid-word: 5 digits then rst_n pulse, then "FFFFFFFF" -> single write, addr 0, wdata 0xFFFFFFFF.
